// File: rtl/ex_divseq.sv
// Iterative radix-2 restoring divider for 64-bit signed/unsigned DIV/DIVU.
// One operation in flight; the quotient, remainder and tag return over a valid/ready handshake.
module ex_divseq #(
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [63:0]      in1,
  input  logic [63:0]      in2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out,
  output logic [63:0]      out2,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             out_valid_d;
  logic [XLEN-1:0]  out_d, out2_d;
  logic [TAG_W-1:0] out_tag_d;

  logic [XLEN-1:0]  mag1_c, mag2_c;
  logic [XLEN:0]    shifted_c;
  logic             fits_c;

  assign in_ready = (state_q == S_IDLE);

  // Operand magnitudes; negating MIN yields 2^63 as an unsigned value.
  assign mag1_c = (in_signed && in1[XLEN-1]) ? (-in1) : in1;
  assign mag2_c = (in_signed && in2[XLEN-1]) ? (-in2) : in2;

  // The shifted remainder keeps its carry-out bit so divisors above 2^63 still compare correctly.
  assign shifted_c = {rem_q, quo_q[XLEN-1]};
  assign fits_c    = (shifted_c >= {1'b0, dvs_q});

  // Next-state and datapath decode.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    tag_d       = tag_q;
    out_valid_d = out_valid;
    out_d       = out;
    out2_d      = out2;
    out_tag_d   = out_tag;

    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            tag_d   = in_tag;
            neg_q_d = in_signed & (in1[XLEN-1] ^ in2[XLEN-1]);
            neg_r_d = in_signed & in1[XLEN-1];
            rem_d   = '0;
            quo_d   = mag1_c;
            dvs_d   = mag2_c;
            cnt_d   = '0;
            if (in2 == '0) begin
              out_d     = ALL_ONES;
              out2_d    = in1;
              out_tag_d = in_tag;
              state_d   = S_DONE;
            end else if (in_signed && (in1 == MIN_NEG) && (in2 == ALL_ONES)) begin
              out_d     = in1;
              out2_d    = '0;
              out_tag_d = in_tag;
              state_d   = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          if (fits_c) begin
            rem_d = XLEN'(shifted_c - {1'b0, dvs_q});
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shifted_c[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == {CNT_W{1'b1}}) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          out_d     = neg_q_q ? (-quo_q) : quo_q;
          out2_d    = neg_r_q ? (-rem_q) : rem_q;
          out_tag_d = tag_q;
          state_d   = S_DONE;
        end
        S_DONE: begin
          // out_valid rises one edge after entering DONE; the result is taken only once it is visible.
          if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            out_valid_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      tag_q     <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      out2      <= '0;
      out_tag   <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      tag_q     <= tag_d;
      out_valid <= out_valid_d;
      out       <= out_d;
      out2      <= out2_d;
      out_tag   <= out_tag_d;
    end
  end

endmodule

// File: tb/tb_ex_divseq.sv
// Self-checking bench for ex_divseq: directed scenarios plus a randomized run
// against an arithmetic reference model using Verilog / and %.
module tb_ex_divseq;

  localparam int unsigned TAG_W = 6;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_signed = 1'b0;
  logic [63:0]      in1 = '0;
  logic [63:0]      in2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [63:0]      out;
  logic [63:0]      out2;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  ex_divseq #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in1(in1), .in2(in2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out2(out2), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: truncating division with the zero-divisor and overflow rules.
  function automatic void model(input bit s, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] q, output logic [63:0] r);
    logic signed [63:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 64'd0) begin
      q = ONES;
      r = a;
    end else if (s && a == MIN64 && b == ONES) begin
      q = a;
      r = 64'd0;
    end else if (s) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit s, input logic [63:0] a, input logic [63:0] b,
                       input logic [TAG_W-1:0] t);
    in_signed = s;
    in1 = a;
    in2 = b;
    in_tag = t;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out !== 64'd0) begin errors++; $display("FAIL reset_out got %h want 0", out); end
    checks++; if (out2 !== 64'd0) begin errors++; $display("FAIL reset_out2 got %h want 0", out2); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unsigned;
    int cyc;
    bit ready_low;
    issue(1'b0, 64'd100, 64'd7, 6'd5);
    cyc = 0;
    ready_low = 1'b1;
    while (out_valid !== 1'b1 && cyc < 200) begin
      if (in_ready !== 1'b0) ready_low = 1'b0;
      tick();
      cyc++;
    end
    checks++; if (cyc != 66) begin errors++; $display("FAIL udiv_latency got %0d want 66", cyc); end
    checks++; if (ready_low !== 1'b1) begin errors++; $display("FAIL udiv_busy_ready got high want low"); end
    checks++; if (out !== 64'd14) begin errors++; $display("FAIL udiv_q got %0d want 14", out); end
    checks++; if (out2 !== 64'd2) begin errors++; $display("FAIL udiv_r got %0d want 2", out2); end
    checks++; if (out_tag !== 6'd5) begin errors++; $display("FAIL udiv_tag got %0d want 5", out_tag); end
    consume();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL udiv_drop_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL udiv_ready_after got %b want 1", in_ready); end
    checks++; if (out !== 64'd14) begin errors++; $display("FAIL udiv_hold_q got %0d want 14", out); end
  endtask

  task automatic test_signed;
    logic [63:0] ca[4], cb[4], cq[4], cr[4];
    bit cs[4];
    int cyc;
    ca = '{-64'sd100, 64'd100, -64'sd100, ONES};
    cb = '{64'd7, -64'sd7, -64'sd7, 64'd1};
    cq = '{-64'sd14, -64'sd14, 64'd14, ONES};
    cr = '{-64'sd2, 64'd2, -64'sd2, 64'd0};
    cs = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      issue(cs[i], ca[i], cb[i], TAG_W'(10 + i));
      wait_valid(cyc);
      checks++; if (cyc != 66) begin errors++; $display("FAIL sdiv%0d_latency got %0d want 66", i, cyc); end
      checks++; if (out !== cq[i]) begin errors++; $display("FAIL sdiv%0d_q got %h want %h", i, out, cq[i]); end
      checks++; if (out2 !== cr[i]) begin errors++; $display("FAIL sdiv%0d_r got %h want %h", i, out2, cr[i]); end
      consume();
    end
  endtask

  task automatic test_special;
    logic [63:0] ca[4], cb[4], cq[4], cr[4];
    bit cs[4];
    int cl[4];
    int cyc;
    ca = '{64'h1234, 64'h1234, MIN64, MIN64};
    cb = '{64'd0, 64'd0, ONES, ONES};
    cq = '{ONES, ONES, MIN64, 64'd0};
    cr = '{64'h1234, 64'h1234, 64'd0, MIN64};
    cs = '{1'b0, 1'b1, 1'b1, 1'b0};
    cl = '{1, 1, 1, 66};
    for (int i = 0; i < 4; i++) begin
      issue(cs[i], ca[i], cb[i], TAG_W'(20 + i));
      wait_valid(cyc);
      checks++; if (cyc != cl[i]) begin errors++; $display("FAIL spec%0d_latency got %0d want %0d", i, cyc, cl[i]); end
      checks++; if (out !== cq[i]) begin errors++; $display("FAIL spec%0d_q got %h want %h", i, out, cq[i]); end
      checks++; if (out2 !== cr[i]) begin errors++; $display("FAIL spec%0d_r got %h want %h", i, out2, cr[i]); end
      checks++; if (out_tag !== TAG_W'(20 + i)) begin errors++; $display("FAIL spec%0d_tag got %0d want %0d", i, out_tag, 20 + i); end
      consume();
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    bit stable;
    issue(1'b0, 64'd1000, 64'd3, 6'd7);
    wait_valid(cyc);
    checks++; if (cyc != 66) begin errors++; $display("FAIL bp_latency got %0d want 66", cyc); end
    checks++; if (out !== 64'd333 || out2 !== 64'd1) begin errors++; $display("FAIL bp_result got %0d/%0d want 333/1", out, out2); end
    in_signed = 1'b1;
    in1 = 64'd50;
    in2 = 64'd5;
    in_tag = 6'd9;
    in_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out !== 64'd333 || out2 !== 64'd1 || out_tag !== 6'd7 || out_valid !== 1'b1 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_hold got unstable want stable"); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_take_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_same_cycle_accept got ready=%b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept got ready=%b want 0", in_ready); end
    wait_valid(cyc);
    checks++; if (cyc != 66) begin errors++; $display("FAIL bp2_latency got %0d want 66", cyc); end
    checks++; if (out !== 64'd10 || out2 !== 64'd0) begin errors++; $display("FAIL bp2_result got %0d/%0d want 10/0", out, out2); end
    checks++; if (out_tag !== 6'd9) begin errors++; $display("FAIL bp2_tag got %0d want 9", out_tag); end
    consume();
  endtask

  task automatic test_flush;
    int cyc;
    logic [63:0] held;
    issue(1'b0, 64'd123456789, 64'd77, 6'd3);
    for (int i = 0; i < 30; i++) tick();
    held = out;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_calc got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    checks++; if (out !== held) begin errors++; $display("FAIL flush_calc_hold got %h want %h", out, held); end
    for (int i = 0; i < 70; i++) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_calc_lost got valid=%b want 0", out_valid); end
    issue(1'b0, 64'd50, 64'd5, 6'd4);
    wait_valid(cyc);
    checks++; if (cyc != 66 || out !== 64'd10 || out2 !== 64'd0 || out_tag !== 6'd4) begin
      errors++; $display("FAIL flush_after got lat=%0d %0d/%0d tag %0d want 66 10/0 tag 4", cyc, out, out2, out_tag);
    end
    flush = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_done got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    checks++; if (out !== 64'd10) begin errors++; $display("FAIL flush_done_hold got %0d want 10", out); end
    issue(1'b0, 64'd77, 64'd0, 6'd1);
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_blocks_accept got ready=%b want 1", in_ready); end
    issue(1'b0, 64'd50, 64'd5, 6'd8);
    wait_valid(cyc);
    checks++; if (cyc != 66 || out !== 64'd10 || out2 !== 64'd0 || out_tag !== 6'd8) begin
      errors++; $display("FAIL flush_done_after got lat=%0d %0d/%0d tag %0d want 66 10/0 tag 8", cyc, out, out2, out_tag);
    end
    consume();
  endtask

  task automatic test_async_reset;
    issue(1'b1, -64'sd999, 64'd13, 6'd2);
    for (int i = 0; i < 20; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 64'd0) begin
      errors++; $display("FAIL areset got ready=%b valid=%b out=%h want 1/0/0", in_ready, out_valid, out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_lost got valid=%b want 0", out_valid); end
  endtask

  task automatic test_random;
    localparam int N = 500;
    logic [63:0] eq[$], er[$];
    logic [TAG_W-1:0] et[$];
    logic [63:0] a, b, q, r, wq, wr;
    logic [TAG_W-1:0] wt;
    int issued, got, cyc;
    issued = 0;
    got = 0;
    cyc = 0;
    while (got < N && cyc < 60000) begin
      if (issued < N) begin
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()} >> ($urandom() % 64);
        case ($urandom() % 8)
          0: b = 64'd0;
          1: begin a = MIN64; b = ONES; end
          2: a = a >> ($urandom() % 64);
          default: ;
        endcase
        in1 = a;
        in2 = b;
        in_signed = $urandom() % 2;
        in_tag = TAG_W'(issued);
        in_valid = ($urandom() % 2) == 0;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom() % 4) != 0;
      if (in_valid && in_ready) begin
        model(in_signed, in1, in2, q, r);
        eq.push_back(q);
        er.push_back(r);
        et.push_back(in_tag);
        issued++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (eq.size() == 0) begin
          errors++; $display("FAIL rnd_spurious got result %h with nothing outstanding", out);
        end else begin
          wq = eq.pop_front();
          wr = er.pop_front();
          wt = et.pop_front();
          if (out !== wq || out2 !== wr || out_tag !== wt) begin
            errors++;
            $display("FAIL rnd%0d got q=%h r=%h tag=%0d want q=%h r=%h tag=%0d", got, out, out2, out_tag, wq, wr, wt);
          end
        end
        got++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (got != N) begin errors++; $display("FAIL rnd_timeout got %0d results want %0d", got, N); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
